select_slice: RTL and testbench



---
 rtl/select_slice_extract.sv | 21 ++
 rtl/select_slice.sv | 122 ++++++++++++
 tb/tb_select_slice.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/select_slice_extract.sv
// rtl/select_slice_extract.sv - picks field0 or field1 of a collector beat and zero-extends it
module select_slice_extract #(
  parameter int WIDTH0 = 32,
  parameter int WIDTH1 = 32,
  parameter int OWIDTH = (WIDTH0 > WIDTH1) ? WIDTH0 : WIDTH1
) (
  input  logic                     iSelect,
  input  logic [WIDTH1+WIDTH0-1:0] iData,
  output logic [OWIDTH-1:0]        oField
);

  always_comb begin
    oField = '0;
    if (iSelect) begin
      oField[WIDTH1-1:0] = iData[WIDTH1+WIDTH0-1:WIDTH0];
    end else begin
      oField[WIDTH0-1:0] = iData[WIDTH0-1:0];
    end
  end

endmodule

// File: rtl/select_slice.sv
// rtl/select_slice.sv - registered field-select slice with a two-entry skid buffer
module select_slice #(
  parameter int WIDTH0 = 32,
  parameter int WIDTH1 = 32,
  parameter int OWIDTH = (WIDTH0 > WIDTH1) ? WIDTH0 : WIDTH1
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iValid_AS,
  output logic                     oReady_AS,
  input  logic                     iSelect_AS,
  input  logic [WIDTH1+WIDTH0-1:0] iData_AS,
  output logic                     oValid_BM,
  input  logic                     iReady_BM,
  output logic                     oSelect_BM,
  output logic [OWIDTH-1:0]        oData_BM
);

  if (OWIDTH < WIDTH0 || OWIDTH < WIDTH1) begin : g_bad_owidth
    $error("select_slice: OWIDTH must be >= WIDTH0 and WIDTH1");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, ready_q;
  logic                main_sel_q, skid_sel_q;
  logic [OWIDTH-1:0]   main_data_q, skid_data_q;
  logic [OWIDTH-1:0]   ext_field;
  logic                in_fire, out_fire;
  logic                load_main, load_skid, main_from_skid;

  // Extraction happens before storage so only OWIDTH+1 bits are kept per entry.
  select_slice_extract #(
    .WIDTH0(WIDTH0),
    .WIDTH1(WIDTH1),
    .OWIDTH(OWIDTH)
  ) u_extract (
    .iSelect(iSelect_AS),
    .iData  (iData_AS),
    .oField (ext_field)
  );

  assign in_fire  = iValid_AS && ready_q;
  assign out_fire = valid_q && iReady_BM;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Valid/ready are flopped from the next state so neither port sees a comb path.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != ST_EMPTY);
      ready_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      main_data_q <= '0;
      main_sel_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data_q <= ext_field;
        main_sel_q  <= iSelect_AS;
      end else if (main_from_skid) begin
        main_data_q <= skid_data_q;
        main_sel_q  <= skid_sel_q;
      end
      if (load_skid) begin
        skid_data_q <= ext_field;
        skid_sel_q  <= iSelect_AS;
      end
    end
  end

  assign oValid_BM  = valid_q;
  assign oReady_AS  = ready_q;
  assign oSelect_BM = main_sel_q;
  assign oData_BM   = main_data_q;

endmodule

// File: tb/tb_select_slice.sv
// tb/tb_select_slice.sv - directed and random self-checking bench for select_slice
module tb_select_slice;

  localparam int W0 = 8;
  localparam int W1 = 16;
  localparam int OW = 16;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iValid_AS;
  logic          oReady_AS;
  logic          iSelect_AS;
  logic [W1+W0-1:0] iData_AS;
  logic          oValid_BM;
  logic          iReady_BM;
  logic          oSelect_BM;
  logic [OW-1:0] oData_BM;

  int errors = 0;
  int checks = 0;

  logic [16:0] sbq[$];
  logic [16:0] exp_beat;
  logic [16:0] prev_out;
  logic        prev_stall;
  logic        in_fire, out_fire, rdy_a, rdy_b;

  select_slice #(.WIDTH0(W0), .WIDTH1(W1), .OWIDTH(OW)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iValid_AS (iValid_AS),
    .oReady_AS (oReady_AS),
    .iSelect_AS(iSelect_AS),
    .iData_AS  (iData_AS),
    .oValid_BM (oValid_BM),
    .iReady_BM (iReady_BM),
    .oSelect_BM(oSelect_BM),
    .oData_BM  (oData_BM)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic sel, input logic [23:0] d);
    return sel ? {1'b1, d[23:8]} : {1'b0, 8'h00, d[7:0]};
  endfunction

  task automatic to_drive;
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [23:0] d);
    iValid_AS  = v;
    iSelect_AS = s;
    iData_AS   = d;
  endtask

  initial begin
    iRst_n = 1'b0; iReady_BM = 1'b0;
    drive(1'b1, 1'b1, 24'hFFFFFF);

    // reset held 3 cycles with valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      check("rst_valid", oValid_BM, 0);
      check("rst_ready", oReady_AS, 0);
      check("rst_data", oData_BM, 0);
      to_drive();
    end
    iRst_n = 1'b1; drive(1'b0, 1'b0, 24'h0);
    @(negedge iClk);
    check("ready_at_release", oReady_AS, 0);
    to_drive();
    @(negedge iClk);
    check("ready_after_release", oReady_AS, 1);
    check("valid_after_release", oValid_BM, 0);

    // field select
    to_drive();
    iReady_BM = 1'b1;
    drive(1'b1, 1'b0, 24'hABCD5A);
    to_drive();
    drive(1'b1, 1'b1, 24'hABCD5A);
    @(negedge iClk);
    check("sel0_valid", oValid_BM, 1);
    check("sel0_data", oData_BM, 32'h005A);
    check("sel0_tag", oSelect_BM, 0);
    to_drive();
    drive(1'b0, 1'b0, 24'h0);
    @(negedge iClk);
    check("sel1_data", oData_BM, 32'hABCD);
    check("sel1_tag", oSelect_BM, 1);
    to_drive();
    @(negedge iClk);
    check("sel_drained", oValid_BM, 0);

    // streaming 16 back-to-back beats
    for (int i = 0; i < 16; i++) begin
      to_drive();
      drive(1'b1, i[0], {8'(i * 3 + 1), 8'(i * 5 + 2), 8'(i * 7 + 3)});
      @(negedge iClk);
      check("stream_ready", oReady_AS, 1);
      if (i > 0) begin
        exp_beat = model((i - 1) % 2 == 1, {8'((i - 1) * 3 + 1), 8'((i - 1) * 5 + 2), 8'((i - 1) * 7 + 3)});
        check("stream_valid", oValid_BM, 1);
        check("stream_beat", {oSelect_BM, oData_BM}, exp_beat);
      end
    end
    to_drive();
    drive(1'b0, 1'b0, 24'h0);
    @(negedge iClk);
    check("stream_last", {oSelect_BM, oData_BM}, model(1'b1, {8'd46, 8'd77, 8'd108}));

    // backpressure A, B, C
    to_drive();
    iReady_BM = 1'b0;
    drive(1'b1, 1'b0, 24'h0000A1);
    to_drive();
    drive(1'b1, 1'b1, 24'hB2B200);
    @(negedge iClk);
    check("bp_a_valid", oValid_BM, 1);
    check("bp_a_data", oData_BM, 32'h00A1);
    check("bp_busy_ready", oReady_AS, 1);
    to_drive();
    drive(1'b1, 1'b0, 24'h0000C3);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      check("bp_full_ready", oReady_AS, 0);
      check("bp_stall_a", {oSelect_BM, oData_BM}, 17'h000A1);
      to_drive();
    end
    iReady_BM = 1'b1;
    @(negedge iClk);
    check("bp_release_a", {oSelect_BM, oData_BM}, 17'h000A1);
    to_drive();
    @(negedge iClk);
    check("bp_b", {oSelect_BM, oData_BM}, 17'h1B2B2);
    check("bp_b_ready", oReady_AS, 1);
    to_drive();
    drive(1'b0, 1'b0, 24'h0);
    @(negedge iClk);
    check("bp_c", {oSelect_BM, oData_BM}, 17'h000C3);
    to_drive();
    @(negedge iClk);
    check("bp_empty", oValid_BM, 0);

    // reset while FULL drops held beats
    to_drive();
    iReady_BM = 1'b0;
    drive(1'b1, 1'b0, 24'h000011);
    to_drive();
    drive(1'b1, 1'b0, 24'h000022);
    to_drive();
    drive(1'b0, 1'b0, 24'h0);
    @(negedge iClk);
    check("mid_full", oReady_AS, 0);
    to_drive();
    iRst_n = 1'b0;
    to_drive();
    iRst_n = 1'b1;
    @(negedge iClk);
    check("mid_rst_valid", oValid_BM, 0);
    check("mid_rst_ready", oReady_AS, 0);
    to_drive();
    iReady_BM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      check("mid_no_ghost", oValid_BM, 0);
      to_drive();
    end

    // random traffic against a FIFO scoreboard
    prev_stall = 1'b0;
    prev_out = '0;
    in_fire = 1'b0;
    drive(1'b0, 1'b0, 24'h0);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!iValid_AS || in_fire) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
      end
      iReady_BM = 1'($urandom_range(0, 1));
      @(negedge iClk);
      rdy_a = oReady_AS;
      iReady_BM = ~iReady_BM;
      #1;
      rdy_b = oReady_AS;
      iReady_BM = ~iReady_BM;
      #1;
      check("rnd_ready_indep", rdy_b, rdy_a);
      check("rnd_valid", oValid_BM, sbq.size() != 0);
      if (prev_stall) check("rnd_stable", {oSelect_BM, oData_BM}, prev_out);
      in_fire  = iValid_AS && oReady_AS;
      out_fire = oValid_BM && iReady_BM;
      prev_stall = oValid_BM && !iReady_BM;
      prev_out = {oSelect_BM, oData_BM};
      if (out_fire) begin
        if (sbq.size() == 0) check("rnd_underflow", 1, 0);
        else begin
          exp_beat = sbq.pop_front();
          check("rnd_beat", {oSelect_BM, oData_BM}, exp_beat);
        end
      end
      if (in_fire) sbq.push_back(model(iSelect_AS, iData_AS));
      to_drive();
    end
    if (in_fire) drive(1'b0, 1'b0, 24'h0);
    iReady_BM = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge iClk);
      in_fire  = iValid_AS && oReady_AS;
      out_fire = oValid_BM && iReady_BM;
      if (out_fire) begin
        if (sbq.size() == 0) check("drain_underflow", 1, 0);
        else begin
          exp_beat = sbq.pop_front();
          check("drain_beat", {oSelect_BM, oData_BM}, exp_beat);
        end
      end
      if (in_fire) sbq.push_back(model(iSelect_AS, iData_AS));
      to_drive();
      drive(1'b0, 1'b0, 24'h0);
    end
    check("drain_empty", sbq.size(), 0);
    check("drain_valid", oValid_BM, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
